// File: rtl/convolution_filter.sv
// Streaming 2-D correlation filter: line buffers feed a causal KERNEL_H x KERNEL_W window,
// products and a reduce/scale/saturate stage produce one unsigned pixel per accepted input.
module convolution_filter #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int KERNEL_H   = 3,
    parameter int KERNEL_W   = 3,
    parameter int W          = 8,
    parameter int W_FRAC     = 0
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        x_valid,
    output logic                                        x_ready,
    input  logic [W-1:0]                                x_data,
    input  logic [0:KERNEL_H-1][0:KERNEL_W-1][W-1:0]    kernel,
    output logic                                        y_valid,
    input  logic                                        y_ready,
    output logic [W-1:0]                                y_data
);

    localparam int CW      = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW      = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int PW      = 2 * W + 1;
    localparam int NTAP    = KERNEL_H * KERNEL_W;
    localparam int AW      = PW + $clog2(NTAP);
    localparam int LB_ROWS = (KERNEL_H > 1) ? KERNEL_H - 1 : 1;

    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic                 vld_p0;
    logic                 vld_p1;
    logic                 s1_ok;
    logic                 s2_ok;
    logic                 xfer;

    logic [W-1:0]         lb       [0:LB_ROWS-1][0:IMG_WIDTH-1];
    logic [W-1:0]         col_pix  [0:KERNEL_H-1];
    logic [W-1:0]         win_next [0:KERNEL_H-1][0:KERNEL_W-1];
    logic [W-1:0]         win_p0   [0:KERNEL_H-1][0:KERNEL_W-1];
    logic signed [W-1:0]  kern_p0  [0:KERNEL_H-1][0:KERNEL_W-1];
    logic signed [PW-1:0] prod_p1  [0:KERNEL_H-1][0:KERNEL_W-1];
    logic signed [AW-1:0] acc_p1;
    logic [W-1:0]         pix_p1;

    function automatic logic signed [AW-1:0] floor_shift(input logic signed [AW-1:0] v);
        return v >>> W_FRAC;
    endfunction

    function automatic logic [W-1:0] abs_sat(input logic signed [AW-1:0] v);
        logic [AW-1:0] mag;
        mag = v[AW-1] ? $unsigned(-v) : $unsigned(v);
        return (|mag[AW-1:W]) ? '1 : mag[W-1:0];
    endfunction

    // A stage may load when it is empty or its content moves on in the same cycle.
    assign s2_ok   = !y_valid || y_ready;
    assign s1_ok   = !vld_p1 || s2_ok;
    assign x_ready = !vld_p0 || s1_ok;
    assign xfer    = x_valid && x_ready;

    // Window assembly: newest column comes from the line buffers plus the incoming pixel.
    // Out-of-image taps are zeroed from the counters; a zeroed tap stays out of image as it
    // shifts left, so storing the masked window is safe across rows and frames.
    always_comb begin
        col_pix[KERNEL_H-1] = x_data;
        for (int k = 0; k < KERNEL_H - 1; k++) begin
            col_pix[KERNEL_H-2-k] = lb[k][col];
        end
        for (int i = 0; i < KERNEL_H; i++) begin
            for (int j = 0; j < KERNEL_W - 1; j++) begin
                win_next[i][j] = win_p0[i][j+1];
            end
            win_next[i][KERNEL_W-1] = col_pix[i];
        end
        for (int i = 0; i < KERNEL_H; i++) begin
            for (int j = 0; j < KERNEL_W; j++) begin
                if (int'(row) < KERNEL_H - 1 - i || int'(col) < KERNEL_W - 1 - j) begin
                    win_next[i][j] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col     <= '0;
            row     <= '0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            y_valid <= 1'b0;
            y_data  <= '0;
        end else begin
            if (xfer) begin
                if (col == CW'(IMG_WIDTH - 1)) begin
                    col <= '0;
                    if (row == RW'(IMG_HEIGHT - 1)) begin
                        row <= '0;
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (x_ready) begin
                vld_p0 <= x_valid;
            end
            if (s1_ok) begin
                vld_p1 <= vld_p0;
            end
            if (s2_ok) begin
                y_valid <= vld_p1;
                if (vld_p1) begin
                    y_data <= pix_p1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) begin
            lb[0][col] <= x_data;
            for (int k = 1; k < KERNEL_H - 1; k++) begin
                lb[k][col] <= lb[k-1][col];
            end
        end
    end

    // p0: window and kernel captured on input transfer
    always_ff @(posedge clk) begin
        if (xfer) begin
            for (int i = 0; i < KERNEL_H; i++) begin
                for (int j = 0; j < KERNEL_W; j++) begin
                    win_p0[i][j]  <= win_next[i][j];
                    kern_p0[i][j] <= $signed(kernel[i][j]);
                end
            end
        end
    end

    // p1: per-tap products, pixel zero-extended to a signed operand
    always_ff @(posedge clk) begin
        if (vld_p0 && s1_ok) begin
            for (int i = 0; i < KERNEL_H; i++) begin
                for (int j = 0; j < KERNEL_W; j++) begin
                    prod_p1[i][j] <= PW'($signed({1'b0, win_p0[i][j]})) * PW'(kern_p0[i][j]);
                end
            end
        end
    end

    // p2: reduce, floor shift, absolute value and saturation into y_data
    always_comb begin
        acc_p1 = '0;
        for (int i = 0; i < KERNEL_H; i++) begin
            for (int j = 0; j < KERNEL_W; j++) begin
                acc_p1 = acc_p1 + AW'(prod_p1[i][j]);
            end
        end
        pix_p1 = abs_sat(floor_shift(acc_p1));
    end

endmodule

// File: tb/tb_convolution_filter.sv
// Bench for convolution_filter on an 8x6 image with a 3x3 kernel: scoreboard against a
// direct correlation model, a table of hand-derived pixels, and stall/reset/fraction sequences.
module tb_convolution_filter;

    localparam int IW   = 8;
    localparam int IH   = 6;
    localparam int NPIX = IW * IH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                   x_valid, x_ready, y_valid, y_ready;
    logic [7:0]             x_data, y_data;
    logic [0:2][0:2][7:0]   kernel;
    logic                   f_x_valid, f_x_ready, f_y_valid, f_y_ready;
    logic [7:0]             f_x_data, f_y_data;
    logic [0:2][0:2][7:0]   f_kernel;

    convolution_filter #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH), .KERNEL_H(3), .KERNEL_W(3),
                         .W(8), .W_FRAC(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .kernel(kernel), .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data));

    convolution_filter #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH), .KERNEL_H(3), .KERNEL_W(3),
                         .W(8), .W_FRAC(4)) u_frac (
        .clk(clk), .rst_n(rst_n), .x_valid(f_x_valid), .x_ready(f_x_ready), .x_data(f_x_data),
        .kernel(f_kernel), .y_valid(f_y_valid), .y_ready(f_y_ready), .y_data(f_y_data));

    typedef struct {
        int kind;
        int r;
        int c;
        int exp;
    } vec_t;

    int   ktb [0:2][0:2];
    int   img [0:NPIX-1];
    int   cap [0:NPIX-1];
    int   ref_cap [0:NPIX-1];
    int   sb_q[$];
    vec_t tbl[$];
    int   n_vec = 0, n_fail = 0;
    int   nneg = 0, in_pos = 0, out_pos = 0, out_total = 0;
    int   in_edge = -1, first_out = -1, stall_run = 0, burst = 0;
    bit   prev_stall = 1'b0, bp_mode = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic int model(input int pos);
        int r, c, acc, rr, cc;
        r = pos / IW;
        c = pos % IW;
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                rr = r - 2 + i;
                cc = c - 2 + j;
                if (rr >= 0 && cc >= 0) acc += ktb[i][j] * img[rr * IW + cc];
            end
        end
        if (acc < 0) acc = -acc;
        if (acc > 255) acc = 255;
        return acc;
    endfunction

    always @(negedge clk) begin
        nneg++;
        if (rst_n) begin
            if (x_valid && x_ready) begin
                sb_q.push_back(model(in_pos));
                if (in_edge < 0) in_edge = nneg + 1;
                in_pos = (in_pos + 1) % NPIX;
            end
            if (prev_stall) begin
                check("stall_valid", int'(y_valid), 1);
                check("stall_data", int'(y_data), int'(prev_data));
            end
            if (y_valid && !y_ready && x_valid) stall_run++;
            else stall_run = 0;
            if (stall_run == 3) check("x_ready_after_stall", int'(x_ready), 0);
            if (y_valid && y_ready) begin
                if (first_out < 0) first_out = nneg;
                if (sb_q.size() == 0) check("unexpected_output", int'(y_data), -1);
                else check($sformatf("pix%0d", out_pos), int'(y_data), sb_q.pop_front());
                cap[out_pos] = int'(y_data);
                out_pos = (out_pos + 1) % NPIX;
                out_total++;
            end
            prev_stall = y_valid && !y_ready;
            prev_data  = y_data;
        end
    end

    initial begin
        y_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                if (burst > 0) begin
                    burst--;
                    y_ready = 1'b0;
                end else if ($urandom_range(0, 19) == 0) begin
                    burst = 9;
                    y_ready = 1'b0;
                end else begin
                    y_ready = 1'($urandom_range(0, 1));
                end
            end else begin
                y_ready = 1'b1;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic set_kernel(input int which);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                case (which)
                    0: ktb[i][j] = 1;
                    1: ktb[i][j] = (i == 2 && j == 2) ? 1 : 0;
                    2: ktb[i][j] = (i == 0 && j == 0) ? 1 : 0;
                    3: ktb[i][j] = (i == 1 && j == 1) ? -8 : 1;
                    default: ktb[i][j] = (j - 1) * ((i == 1) ? 2 : 1);
                endcase
                kernel[i][j] = 8'(ktb[i][j]);
            end
    endtask

    task automatic set_image(input int which, input int v);
        for (int p = 0; p < NPIX; p++) begin
            case (which)
                0: img[p] = v;
                1: img[p] = p;
                2: img[p] = (p == 2 * IW + 2) ? v : 0;
                default: img[p] = int'($urandom_range(0, 255));
            endcase
        end
    endtask

    task automatic push_pix(input int v, input bit gaps);
        bit ok;
        if (gaps && $urandom_range(0, 3) == 0) begin
            x_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        x_valid = 1'b1;
        x_data  = 8'(v);
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = x_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) check("x_handshake_timeout", 0, 1);
    endtask

    task automatic drive(input int n, input bit gaps);
        for (int p = 0; p < n; p++) push_pix(img[p % NPIX], gaps);
    endtask

    task automatic drain();
        x_valid = 1'b0;
        for (int t = 0; t < 400 && sb_q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("drain", sb_q.size(), 0);
    endtask

    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_y_valid", int'(y_valid), 0);
        check("rst_y_data", int'(y_data), 0);
        x_valid = 1'b0;
        sb_q.delete();
        in_pos = 0;
        out_pos = 0;
        prev_stall = 1'b0;
        stall_run = 0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check("rst_x_ready", int'(x_ready), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input int kind);
        case (kind)
            0: begin set_kernel(0); set_image(0, 20);  drive(NPIX, 0); drain(); end
            1: begin set_kernel(0); set_image(0, 100); drive(NPIX, 0); drain(); end
            2: begin set_kernel(3); set_image(0, 50);  drive(NPIX, 0); drain(); end
            3: begin set_kernel(3); set_image(2, 10);  drive(NPIX, 0); drain(); end
            4: begin
                set_kernel(1); set_image(1, 0);
                in_edge = -1; first_out = -1; out_total = 0;
                drive(NPIX, 0); drain();
                check("latency", first_out - in_edge, 2);
                check("output_count", out_total, NPIX);
            end
            5: begin
                set_kernel(2); set_image(1, 0); drive(NPIX, 0);
                set_image(0, 200); drive(NPIX, 0); drain();
            end
            default: begin
                set_kernel(0); set_image(0, 200); drive(20, 0);
                mid_reset();
                set_image(0, 20); drive(NPIX, 0); drain();
            end
        endcase
    endtask

    initial begin
        int cur;
        int got;
        tbl.push_back('{4, 0, 0, 0});   tbl.push_back('{4, 2, 3, 19});  tbl.push_back('{4, 5, 7, 47});
        tbl.push_back('{0, 0, 0, 20});  tbl.push_back('{0, 0, 1, 40});  tbl.push_back('{0, 1, 1, 80});
        tbl.push_back('{0, 0, 5, 60});  tbl.push_back('{0, 3, 3, 180});
        tbl.push_back('{1, 0, 0, 100}); tbl.push_back('{1, 3, 3, 255});
        tbl.push_back('{2, 0, 0, 50});  tbl.push_back('{2, 3, 3, 0});   tbl.push_back('{2, 5, 7, 0});
        tbl.push_back('{3, 2, 2, 10});  tbl.push_back('{3, 3, 3, 80});  tbl.push_back('{3, 4, 4, 10});
        tbl.push_back('{3, 3, 2, 10});
        tbl.push_back('{5, 0, 7, 0});   tbl.push_back('{5, 1, 7, 0});   tbl.push_back('{5, 1, 3, 0});
        tbl.push_back('{5, 3, 1, 0});   tbl.push_back('{5, 2, 2, 200}); tbl.push_back('{5, 5, 7, 200});
        tbl.push_back('{6, 0, 0, 20});  tbl.push_back('{6, 0, 1, 40});  tbl.push_back('{6, 1, 0, 40});
        tbl.push_back('{6, 1, 1, 80});  tbl.push_back('{6, 4, 4, 180});

        x_valid = 1'b0; x_data = '0; kernel = '0;
        f_x_valid = 1'b0; f_x_data = '0; f_kernel = '0; f_y_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        check("reset_y_valid", int'(y_valid), 0);
        check("reset_y_data", int'(y_data), 0);
        rst_n = 1'b1;
        #1;
        check("reset_x_ready", int'(x_ready), 1);
        @(posedge clk);
        #1;

        // Fixed-point kernel: 16 is 1.0 and 8 is 0.5 with four fractional bits.
        for (int n = 0; n < 2; n++) begin
            f_kernel[2][2] = (n == 0) ? 8'd16 : 8'd8;
            f_x_valid = 1'b1;
            f_x_data  = 8'd77;
            @(posedge clk);
            #1;
            f_x_valid = 1'b0;
            got = -1;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (f_y_valid) begin
                    got = int'(f_y_data);
                    break;
                end
            end
            check((n == 0) ? "frac_one" : "frac_half", got, (n == 0) ? 77 : 38);
            @(posedge clk);
            #1;
        end

        cur = -1;
        foreach (tbl[n]) begin
            if (tbl[n].kind != cur) begin
                cur = tbl[n].kind;
                setup(cur);
            end
            check($sformatf("k%0d_r%0d_c%0d", tbl[n].kind, tbl[n].r, tbl[n].c),
                  cap[tbl[n].r * IW + tbl[n].c], tbl[n].exp);
        end

        // Same image and signed kernel with and without backpressure must match pixel for pixel.
        set_kernel(4);
        set_image(3, 0);
        drive(NPIX, 0);
        drain();
        for (int p = 0; p < NPIX; p++) ref_cap[p] = cap[p];
        bp_mode = 1'b1;
        drive(2 * NPIX, 1);
        bp_mode = 1'b0;
        drain();
        for (int p = 0; p < NPIX; p++) check($sformatf("bp_seq%0d", p), cap[p], ref_cap[p]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
